muldiv_hilo: RTL and testbench

- Multi-cycle multiply/divide unit with architectural HI/LO registers for the Mips31 datapath.
- Sits directly downstream of RegFile. It consumes the Rs/Rt read ports as operands for MULT/MULTU/DIV/DIVU.
- Supplies HI/LO for MFHI/MFLO and accepts MTHI/MTLO writes.
- Raises busy so the control unit can stall the pipeline during iteration.

---
 rtl/muldiv_hilo.sv | 163 ++++++++++++++++
 tb/tb_muldiv_hilo.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_hilo.sv
// Iterative multiply/divide unit with HI/LO registers (radix-2 shift-add / restoring divide).
// Define MD_FAST_MUL_EN to replace the iterative multiply with a single-cycle multiplier.
module muldiv_hilo #(
  parameter int WIDTH = 32,
  parameter int ITER  = 32
) (
  input  logic             MD_clk,
  input  logic             MD_rst_n,
  input  logic             MD_ena,
  input  logic             MD_start,
  input  logic [1:0]       MD_op,
  input  logic [WIDTH-1:0] MD_a,
  input  logic [WIDTH-1:0] MD_b,
  input  logic             MD_hi_we,
  input  logic             MD_lo_we,
  input  logic [WIDTH-1:0] MD_wdata,
  output logic             MD_busy,
  output logic             MD_done,
  output logic             MD_div0,
  output logic [WIDTH-1:0] MD_hi,
  output logic [WIDTH-1:0] MD_lo
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;
  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

  logic [1:0]       state_reg;
  logic [CW-1:0]    cnt_reg;
  logic             op_div_reg, op_signed_reg, sign_a_reg, sign_b_reg, div0_flag_reg;
  logic [WIDTH-1:0] opnd_reg, hi_acc_reg, lo_acc_reg;
  logic [WIDTH-1:0] hi_reg, lo_reg;
  logic             done_reg, div0_reg;

  logic             op_signed, op_div, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0] prod_neg;

  assign op_signed = ~MD_op[0];
  assign op_div    = MD_op[1];
  assign a_neg     = op_signed & MD_a[WIDTH-1];
  assign b_neg     = op_signed & MD_b[WIDTH-1];
  assign a_mag     = a_neg ? -MD_a : MD_a;
  assign b_mag     = b_neg ? -MD_b : MD_b;

  // Multiply: {hi_acc, lo_acc} is the product with the multiplier shifting out of the low end.
  assign mul_sum   = {1'b0, hi_acc_reg} + (lo_acc_reg[0] ? {1'b0, opnd_reg} : '0);
  // Divide: hi_acc is the partial remainder, lo_acc shifts dividend out and quotient in.
  assign div_shift = {hi_acc_reg, lo_acc_reg[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opnd_reg};
  assign prod_neg  = -{hi_acc_reg, lo_acc_reg};

`ifdef MD_FAST_MUL_EN
  logic [2*WIDTH-1:0] fast_a, fast_b, fast_prod;
  assign fast_a    = op_signed ? {{WIDTH{MD_a[WIDTH-1]}}, MD_a} : {{WIDTH{1'b0}}, MD_a};
  assign fast_b    = op_signed ? {{WIDTH{MD_b[WIDTH-1]}}, MD_b} : {{WIDTH{1'b0}}, MD_b};
  assign fast_prod = fast_a * fast_b;
`endif

  always_ff @(posedge MD_clk or negedge MD_rst_n) begin
    if (!MD_rst_n) begin
      state_reg     <= S_IDLE;
      cnt_reg       <= '0;
      op_div_reg    <= 1'b0;
      op_signed_reg <= 1'b0;
      sign_a_reg    <= 1'b0;
      sign_b_reg    <= 1'b0;
      div0_flag_reg <= 1'b0;
      opnd_reg      <= '0;
      hi_acc_reg    <= '0;
      lo_acc_reg    <= '0;
      hi_reg        <= '0;
      lo_reg        <= '0;
      done_reg      <= 1'b0;
      div0_reg      <= 1'b0;
    end else begin
      // Pulses last exactly one clock even while the unit is disabled.
      done_reg <= 1'b0;
      div0_reg <= 1'b0;
      if (MD_ena) begin
        case (state_reg)
          S_IDLE: begin
            if (MD_start) begin
              op_div_reg    <= op_div;
              op_signed_reg <= op_signed;
              sign_a_reg    <= a_neg;
              sign_b_reg    <= b_neg;
              cnt_reg       <= '0;
              div0_flag_reg <= 1'b0;
              if (op_div && (MD_b == '0)) begin
                hi_acc_reg    <= MD_a;
                lo_acc_reg    <= '1;
                div0_flag_reg <= 1'b1;
                state_reg     <= S_DONE;
              end else if (op_div) begin
                hi_acc_reg <= '0;
                lo_acc_reg <= a_mag;
                opnd_reg   <= b_mag;
                state_reg  <= S_CALC;
              end else begin
`ifdef MD_FAST_MUL_EN
                {hi_acc_reg, lo_acc_reg} <= fast_prod;
                state_reg                <= S_DONE;
`else
                hi_acc_reg <= '0;
                lo_acc_reg <= b_mag;
                opnd_reg   <= a_mag;
                state_reg  <= S_CALC;
`endif
              end
            end else begin
              if (MD_hi_we) hi_reg <= MD_wdata;
              if (MD_lo_we) lo_reg <= MD_wdata;
            end
          end
          S_CALC: begin
            if (op_div_reg) begin
              hi_acc_reg <= div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
              lo_acc_reg <= {lo_acc_reg[WIDTH-2:0], ~div_diff[WIDTH]};
            end else begin
              {hi_acc_reg, lo_acc_reg} <= {mul_sum, lo_acc_reg[WIDTH-1:1]};
            end
            if (cnt_reg == CW'(ITER - 1)) begin
              cnt_reg   <= '0;
              state_reg <= S_FIX;
            end else begin
              cnt_reg <= cnt_reg + CW'(1);
            end
          end
          S_FIX: begin
            if (op_signed_reg) begin
              if (op_div_reg) begin
                if (sign_a_reg ^ sign_b_reg) lo_acc_reg <= -lo_acc_reg;
                if (sign_a_reg)              hi_acc_reg <= -hi_acc_reg;
              end else if (sign_a_reg ^ sign_b_reg) begin
                {hi_acc_reg, lo_acc_reg} <= prod_neg;
              end
            end
            state_reg <= S_DONE;
          end
          S_DONE: begin
            hi_reg    <= hi_acc_reg;
            lo_reg    <= lo_acc_reg;
            done_reg  <= 1'b1;
            div0_reg  <= div0_flag_reg;
            state_reg <= S_IDLE;
          end
          default: state_reg <= S_IDLE;
        endcase
      end
    end
  end

  assign MD_busy = (state_reg != S_IDLE);
  assign MD_done = done_reg;
  assign MD_div0 = div0_reg;
  assign MD_hi   = hi_reg;
  assign MD_lo   = lo_reg;

endmodule

// File: tb/tb_muldiv_hilo.sv
// Directed + random bench for muldiv_hilo; expected HI/LO/latency come from a scoreboard queue.
module tb_muldiv_hilo;

  logic        MD_clk = 1'b0;
  logic        MD_rst_n = 1'b0;
  logic        MD_ena = 1'b1;
  logic        MD_start = 1'b0;
  logic [1:0]  MD_op = 2'b00;
  logic [31:0] MD_a = '0;
  logic [31:0] MD_b = '0;
  logic        MD_hi_we = 1'b0;
  logic        MD_lo_we = 1'b0;
  logic [31:0] MD_wdata = '0;
  logic        MD_busy, MD_done, MD_div0;
  logic [31:0] MD_hi, MD_lo;

  muldiv_hilo #(.WIDTH(32), .ITER(32)) dut (
    .MD_clk(MD_clk), .MD_rst_n(MD_rst_n), .MD_ena(MD_ena), .MD_start(MD_start),
    .MD_op(MD_op), .MD_a(MD_a), .MD_b(MD_b), .MD_hi_we(MD_hi_we), .MD_lo_we(MD_lo_we),
    .MD_wdata(MD_wdata), .MD_busy(MD_busy), .MD_done(MD_done), .MD_div0(MD_div0),
    .MD_hi(MD_hi), .MD_lo(MD_lo)
  );

  always #5 MD_clk = ~MD_clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div0;
    int          lat;
    string       name;
  } exp_t;

  exp_t sb[$];
  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge MD_clk);
    #1;
    cyc++;
  endtask

  function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic [63:0] ea, eb, p;
    int sa, sb_i;
    e.div0 = 1'b0;
`ifdef MD_FAST_MUL_EN
    e.lat = op[1] ? 34 : 1;
`else
    e.lat = 34;
`endif
    case (op)
      2'b00, 2'b01: begin
        ea = (op == 2'b00) ? {{32{a[31]}}, a} : {32'h0, a};
        eb = (op == 2'b00) ? {{32{b[31]}}, b} : {32'h0, b};
        p = ea * eb;
        e.hi = p[63:32];
        e.lo = p[31:0];
      end
      default: begin
        if (b == 32'h0) begin
          e.hi = a; e.lo = 32'hFFFF_FFFF; e.div0 = 1'b1; e.lat = 1;
        end else if (op == 2'b11) begin
          e.lo = a / b; e.hi = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          e.lo = 32'h8000_0000; e.hi = 32'h0;
        end else begin
          sa = $signed(a); sb_i = $signed(b);
          e.lo = 32'(sa / sb_i); e.hi = 32'(sa % sb_i);
        end
      end
    endcase
    return e;
  endfunction

  task automatic do_start(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int extra);
    exp_t e;
    e = model(op, a, b);
    e.lat += extra;
    e.name = name;
    sb.push_back(e);
    MD_op = op; MD_a = a; MD_b = b; MD_start = 1'b1;
    @(posedge MD_clk);
    #1;
    cyc = 0;
    MD_start = 1'b0; MD_hi_we = 1'b0; MD_lo_we = 1'b0;
    chk({name, ".busy_after_start"}, 64'(MD_busy), 64'd1);
  endtask

  task automatic wait_done();
    exp_t e;
    while (!MD_done && cyc < 200) step();
    if (sb.size() == 0) begin
      chk("scoreboard_nonempty", 64'd0, 64'd1);
      return;
    end
    e = sb.pop_front();
    chk({e.name, ".done"}, 64'(MD_done), 64'd1);
    chk({e.name, ".latency"}, 64'(cyc), 64'(e.lat));
    chk({e.name, ".hi"}, 64'(MD_hi), 64'(e.hi));
    chk({e.name, ".lo"}, 64'(MD_lo), 64'(e.lo));
    chk({e.name, ".div0"}, 64'(MD_div0), 64'(e.div0));
    chk({e.name, ".busy_at_done"}, 64'(MD_busy), 64'd0);
    $display("op %s: hi=%08h lo=%08h div0=%0d latency=%0d", e.name, MD_hi, MD_lo, MD_div0, cyc);
    step();
    chk({e.name, ".done_pulse"}, 64'(MD_done), 64'd0);
    chk({e.name, ".div0_pulse"}, 64'(MD_div0), 64'd0);
  endtask

  initial begin
    exp_t dummy;
    int done_cnt;
    logic [1:0]  rop;
    logic [31:0] ra, rb;

    // Reset state
    step(); step();
    chk("rst.hi", 64'(MD_hi), 64'd0);
    chk("rst.lo", 64'(MD_lo), 64'd0);
    chk("rst.busy", 64'(MD_busy), 64'd0);
    chk("rst.done", 64'(MD_done), 64'd0);
    chk("rst.div0", 64'(MD_div0), 64'd0);
    MD_rst_n = 1'b1;
    step();

    // MTHI / MTLO in IDLE
    MD_hi_we = 1'b1; MD_wdata = 32'h1234_5678;
    step();
    MD_hi_we = 1'b0;
    chk("mthi", 64'(MD_hi), 64'h1234_5678);
    $display("mthi: hi=%08h", MD_hi);
    MD_lo_we = 1'b1; MD_wdata = 32'h0BAD_F00D;
    step();
    MD_lo_we = 1'b0;
    chk("mtlo", 64'(MD_lo), 64'h0BAD_F00D);
    chk("mtlo.hi_kept", 64'(MD_hi), 64'h1234_5678);
    $display("mtlo: lo=%08h", MD_lo);

    // Start with same-cycle MTLO: start wins, write dropped
    MD_lo_we = 1'b1; MD_wdata = 32'hCAFE_CAFE;
    do_start("div_m7_2", 2'b10, 32'hFFFF_FFF9, 32'h2, 0);
    chk("start_vs_mtlo.lo", 64'(MD_lo), 64'h0BAD_F00D);
    step(); step();
    // MTLO and a second start while busy are both ignored
    MD_lo_we = 1'b1; MD_wdata = 32'h5555_5555;
    MD_start = 1'b1; MD_op = 2'b01; MD_a = 32'hFFFF_FFFF; MD_b = 32'h3;
    step(); step();
    MD_lo_we = 1'b0; MD_start = 1'b0;
    chk("mtlo_busy.lo", 64'(MD_lo), 64'h0BAD_F00D);
    chk("mthi_busy.hi", 64'(MD_hi), 64'h1234_5678);
    chk("busy_mid_calc", 64'(MD_busy), 64'd1);
    wait_done();

    // Directed arithmetic cases
    do_start("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    wait_done();
    do_start("mult_m3_5", 2'b00, 32'hFFFF_FFFD, 32'h5, 0);
    wait_done();
    do_start("div_min_m1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    wait_done();
    do_start("divu_100_0", 2'b11, 32'd100, 32'h0, 0);
    wait_done();
    do_start("div_7_m2", 2'b10, 32'd7, 32'hFFFF_FFFE, 0);
    wait_done();

    // Enable held low for 5 cycles mid-CALC
    do_start("div_ena_gap", 2'b10, 32'd1000, 32'd33, 5);
    while (cyc < 10) step();
    MD_ena = 1'b0;
    repeat (5) step();
    chk("ena_low.busy", 64'(MD_busy), 64'd1);
    MD_ena = 1'b1;
    wait_done();

    // Reset mid-operation aborts
    do_start("divu_abort", 2'b11, 32'd50, 32'd7, 0);
    while (cyc < 10) step();
    MD_rst_n = 1'b0;
    #1;
    chk("abort.hi", 64'(MD_hi), 64'd0);
    chk("abort.lo", 64'(MD_lo), 64'd0);
    chk("abort.busy", 64'(MD_busy), 64'd0);
    dummy = sb.pop_front();
    $display("reset mid-op: dropped %s", dummy.name);
    step();
    MD_rst_n = 1'b1;
    done_cnt = 0;
    repeat (40) begin
      step();
      if (MD_done) done_cnt++;
    end
    chk("abort.no_done", 64'(done_cnt), 64'd0);
    do_start("divu_50_7", 2'b11, 32'd50, 32'd7, 0);
    wait_done();

    // Random operations
    for (int i = 0; i < 8; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra = $urandom();
      rb = ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom();
      do_start($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb, 0);
      wait_done();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
